// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller and the PC-select logic that
// consumes its handler address.
package intr_ctrl_pkg;

    // Controller FSM. The encoding is fixed so checkers and the CPU-side
    // debug readback can decode a raw 2-bit state value.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_W     = 10;
    localparam logic [9:0]  DEF_VEC_BASE   = 10'h3C0;
    localparam int unsigned DEF_VEC_STRIDE = 8;

    // Byte distance of handler idx from the vector base; the caller truncates
    // the sum to the PC width, so overflow wraps.
    function automatic int unsigned vec_offset(input int unsigned idx,
                                               input int unsigned stride);
        return idx * stride;
    endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: reports the index of the highest set
// request bit and whether any bit is set.
module prio_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);

    localparam int ID_W = $clog2(WIDTH);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detects request lines into a pending register,
// masks them, and hands the highest-priority one to the CPU via req/ack/ret.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int                WIDTH      = 8,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
    parameter int unsigned       VEC_STRIDE = DEF_VEC_STRIDE,
    parameter logic [WIDTH-1:0]  MASK_RST   = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         irq_in,
    input  logic                     mask_we,
    input  logic [WIDTH-1:0]         mask_wdata,
    input  logic                     int_ack,
    input  logic                     int_ret,
    output logic                     int_req,
    output logic [ADDR_W-1:0]        int_addr,
    output logic [$clog2(WIDTH)-1:0] int_id,
    output logic                     in_service,
    output logic [WIDTH-1:0]         pending,
    output logic [WIDTH-1:0]         mask
);

    localparam int ID_W = $clog2(WIDTH);

    // CPU handshake: int_req stays high in REQ until the CPU pulses int_ack;
    // int_ack is only honoured in REQ and int_ret only in SERVICE, so a stray
    // or simultaneous strobe never moves the FSM out of turn.

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  irq_q, irq_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [ID_W-1:0]   int_id_q, int_id_d;
    logic [ADDR_W-1:0] int_addr_q, int_addr_d;
    logic              int_req_q, int_req_d;
    logic              in_service_q, in_service_d;

    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  clr;
    logic [WIDTH-1:0]  active;
    logic [ID_W-1:0]   prio_idx;
    logic              prio_valid;
    logic              ack_ok;
    logic              ret_ok;

    assign rise   = irq_in & ~irq_q;
    assign active = pending_q & mask_q;

    prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .req   (active),
        .idx   (prio_idx),
        .valid (prio_valid)
    );

    // Pending, mask and edge-detect next state. A new rise in the ack cycle
    // is OR-ed in after the clear, so the set wins.
    always_comb begin
        ack_ok = (state_q == ST_REQ) && int_ack;
        ret_ok = (state_q == ST_SERVICE) && int_ret;
        clr    = '0;
        if (ack_ok) begin
            clr[int_id_q] = 1'b1;
        end
        irq_d     = irq_in;
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_comb begin
        state_d    = state_q;
        int_id_d   = int_id_q;
        int_addr_d = int_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (prio_valid) begin
                    state_d    = ST_REQ;
                    int_id_d   = prio_idx;
                    int_addr_d = VEC_BASE +
                                 ADDR_W'(vec_offset(32'(prio_idx), VEC_STRIDE));
                end
            end
            ST_REQ: begin
                if (ack_ok) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (ret_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Moore outputs registered alongside the state they describe.
        int_req_d    = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            int_id_q     <= '0;
            int_addr_q   <= VEC_BASE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            int_id_q     <= int_id_d;
            int_addr_q   <= int_addr_d;
            int_req_q    <= int_req_d;
            in_service_q <= in_service_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_addr   = int_addr_q;
    assign int_id     = int_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller directly downstream of the periodic timer. It consumes the timer's WIDTH-bit pulse vector (the timer drives the MSB) plus other request lines.
- Latches requests as pending, applies a mask and fixed priority, and issues one request at a time to the single-cycle CPU through a req/ack/ret handshake.
- Produces the handler jump address for the PC-select logic.

Parameters:
- WIDTH, 8, number of request lines; matches the timer's pulse width.
- ADDR_W, 10, width of the handler address (PC width).
- VEC_BASE, 10'h3C0, address of the handler for line 0.
- VEC_STRIDE, 8, address distance between consecutive handlers.
- MASK_RST, {WIDTH{1'b0}}, mask value after reset (1 = enabled).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising clk edge resets the block.
- irq_in  in  WIDTH  request lines; timer pulse on bit WIDTH-1; rising-edge sensitive.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  WIDTH  new mask value.
- int_ack  in  1  CPU has taken the jump to int_addr.
- int_ret  in  1  CPU executed return-from-interrupt.
- int_req  out  1  interrupt request to the CPU.
- int_addr  out  ADDR_W  handler address = VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_W.
- int_id  out  $clog2(WIDTH)  index idx of the line being requested or serviced.
- in_service  out  1  high while a handler runs.
- pending  out  WIDTH  raw pending register, for debug and readback.
- mask  out  WIDTH  current mask register.

Behaviour:
- Reset (reset=0 at an edge):
  - State = IDLE; pending=0; irq_q=0; mask=MASK_RST.
  - int_req=0, in_service=0, int_id=0, int_addr=VEC_BASE.
  - Reset overrides every other input in the same cycle, including mid-handshake.
- Edge detect:
  - irq_q <= irq_in every cycle.
  - rise = irq_in & ~irq_q.
  - A level held high sets pending only once.
- Pending update each edge: pending <= (pending & ~clr) | rise.
  - clr is one-hot(idx) only when the ack is accepted; otherwise 0.
  - Set wins: a new rise on idx in the ack cycle leaves pending[idx]=1.
- Masked lines still latch pending. Unmasking later produces a request.
- Priority: the highest set bit of (pending & mask) wins, so the timer at bit WIDTH-1 is top priority.
- FSM (Moore outputs, all registered):
  - IDLE:
    - int_req=0, in_service=0.
    - If (pending & mask) != 0: latch idx into int_id and int_addr, go to REQ.
  - REQ:
    - int_req=1.
    - int_id and int_addr are held stable even if mask or pending change.
    - On int_ack=1: clear pending[int_id], go to SERVICE.
  - SERVICE:
    - int_req=0, in_service=1.
    - No nesting: new requests stay pending.
    - On int_ret=1: go to IDLE.
- Ignored inputs:
  - int_ack outside REQ is ignored.
  - int_ret outside SERVICE is ignored.
  - int_ack and int_ret in the same cycle: only the one valid for the current state acts.
- Latency:
  - irq_in rises in cycle t; pending is set at the end of t.
  - The FSM leaves IDLE at the end of t+1; int_req=1 from cycle t+2.
  - After int_ret is sampled in cycle s, a further request can assert int_req no earlier than cycle s+2.
- Mask write:
  - mask <= mask_wdata at the edge when mask_we=1.
  - It takes effect for IDLE decisions from the next cycle.
- Arithmetic: int_addr is computed in ADDR_W bits; overflow wraps modulo 2^ADDR_W.

Decomposition:
- Shared package holds:
  - state encoding localparams (ST_IDLE=2'd0, ST_REQ=2'd1, ST_SERVICE=2'd2);
  - default VEC_BASE and VEC_STRIDE constants, so the PC-select mux uses the same values.
- Sub-module prio_enc (combinational, WIDTH-parameterised):
  - outputs the highest set index and a valid flag;
  - instantiated once on pending & mask.

Test Plan:
- Reset and mask: hold reset=0 for 2 cycles, then release; write mask=8'h80, pulse irq_in[7] for 1 cycle at t → int_req=1 at t+2, int_id=7, int_addr=10'h3C0+56=10'h3F8.
- Priority: mask=8'hFF; pulse bits 2 and 7 in the same cycle.
  - First request has int_id=7.
  - After ack and ret, int_id=2 with int_addr=10'h3D0.
  - pending returns to 0.
- Masking: mask=8'h00; pulse bit 3 → pending=8'h08 and int_req stays 0 for 10 cycles; write mask=8'h08 → int_req=1 two cycles after the write.
- Set-wins and level input:
  - Ack idx 7 in the same cycle irq_in[7] rises again → pending[7] stays 1, and a second request follows ret.
  - Hold irq_in[1]=1 for 20 cycles → exactly one request.
- Protocol robustness:
  - int_ret in IDLE and int_ack in SERVICE have no effect.
  - reset=0 asserted while in REQ → next cycle int_req=0, pending=0, mask=MASK_RST.
